mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-low.
REQ-002 iCLK  input  1  clock; all state updates on the rising edge.
REQ-003 iRST  input  1  asynchronous active-low reset.
REQ-004 iStart  input  1  request strobe; sampled on the rising edge.
REQ-005 iControlSignal  input  5  ALU control code from the ALU control stage, using the shared OP* encodings.
REQ-006 iA  input  32  rs operand; dividend or multiplicand.
REQ-007 iB  input  32  rt operand; divisor or multiplier.
REQ-008 oBusy  output  1  high while an iterative operation is in progress; the pipeline stalls on it.
REQ-009 oDone  output  1  one-cycle pulse when a MULT, MULTU, DIV or DIVU result is written.
REQ-010 oDivByZero  output  1  one-cycle pulse, coincident with oDone, for a DIV or DIVU with iB=0.
REQ-011 oHI  output  32  HI register, driven directly from the register and read by MFHI.
REQ-012 oLO  output  32  LO register, driven directly from the register and read by MFLO.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-014 A request SHALL be accepted only on an edge where iStart=1 and the state is IDLE or DONE.
REQ-015 iStart SHALL be ignored in MUL or DIV: no queueing, no effect on the operation in flight.
REQ-016 OPMTHI accepted: oHI <= iA at the accepting edge; state goes to IDLE; oBusy stays 0; oDone stays 0.
REQ-017 OPMTLO accepted: oLO <= iA at the accepting edge; state goes to IDLE; oBusy stays 0; oDone stays 0.
REQ-018 OPMULT or OPMULTU accepted: state goes to MUL; OPDIV or OPDIVU accepted: state goes to DIV.
REQ-019 Any other code with iStart=1 SHALL be ignored.
REQ-020 On acceptance the block SHALL latch operand magnitudes, the result sign and the signed/unsigned flag, and load a 6-bit iteration counter with 32.
REQ-021 MUL SHALL perform radix-2 shift-add, one bit per cycle; DIV SHALL perform restoring division, one bit per cycle.
REQ-022 The counter SHALL decrement once per cycle; after 32 iterations the state SHALL go to DONE and oHI/oLO SHALL be written at that same edge.
REQ-023 Latency: request accepted at edge E0 -> oHI/oLO written at edge E32 -> oDone high during the cycle after E32 -> state leaves DONE at E33.
REQ-024 oBusy SHALL be 1 exactly while the state is MUL or DIV.
REQ-025 From DONE the state SHALL go to IDLE, unless a new request is accepted on that edge, which SHALL then begin normally.
REQ-026 MULT: {HI,LO} SHALL be the 64-bit two's-complement product of iA and iB.
REQ-027 MULTU: {HI,LO} SHALL be the 64-bit unsigned product of iA and iB.
REQ-028 DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
REQ-029 DIVU: LO and HI SHALL be the unsigned quotient and remainder.
REQ-030 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0, with no error flag.
REQ-031 Division by zero (DIV or DIVU, iB=0) SHALL run the full 32 cycles, then give LO=0xFFFFFFFF and HI=iA, and pulse oDivByZero with oDone.
REQ-032 Operands SHALL be captured at acceptance; later changes on iA or iB SHALL NOT affect the result.
REQ-033 oHI/oLO SHALL hold their values between writes; no other condition changes them.

Reset
REQ-034 When iRST=0, immediately and regardless of the clock: state=IDLE, counter=0, oHI=0, oLO=0, oBusy=0, oDone=0, oDivByZero=0.
REQ-035 Reset mid-operation SHALL abort the operation with no result written.
REQ-036 The first request SHALL be accepted on the first rising edge after iRST returns to 1.

Verification
REQ-037 MULT with iA=0xFFFFFFFE (-2), iB=0x00000003 -> oBusy high for 32 cycles, then oHI=0xFFFFFFFF, oLO=0xFFFFFFFA, oDone pulses once.
REQ-038 MULTU with iA=0xFFFFFFFF, iB=0xFFFFFFFF -> oHI=0xFFFFFFFE, oLO=0x00000001.
REQ-039 DIV with iA=-7 (0xFFFFFFF9), iB=2 -> oLO=0xFFFFFFFD (-3), oHI=0xFFFFFFFF (-1); DIVU with iA=7, iB=0 -> oLO=0xFFFFFFFF, oHI=7, oDivByZero pulses with oDone.
REQ-040 OPMTHI with iA=0x12345678 while IDLE -> oHI=0x12345678 after one edge, oBusy stays 0; a second iStart issued mid-DIV -> ignored, DIV result unchanged.
REQ-041 Back-to-back requests: a new MULT issued during DONE -> accepted on that edge, oBusy high on the next cycle, no IDLE cycle in between.
REQ-042 iRST driven low at cycle 10 of a DIV -> oBusy=0 and oHI=oLO=0 immediately, with no oDone; DIV 0x80000000 by -1 afterwards -> oLO=0x80000000, oHI=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Request/result bundle between the ALU control stage and the
//   iterative multiply/divide unit.
//   master : pipeline side. It drives iStart, iControlSignal, iA and iB,
//            and reads oBusy, oDone, oDivByZero, oHI and oLO.
//   slave  : the mult_div_unit itself.
//   iStart         request strobe, sampled on the rising clock edge
//   iControlSignal 5-bit ALU control code (shared OP* encodings)
//   iA / iB        rs / rt operands
//   oBusy          high while a multiply or divide is iterating
//   oDone          one-cycle pulse when a MULT/MULTU/DIV/DIVU result lands
//   oDivByZero     one-cycle pulse alongside oDone for a divide by zero
//   oHI / oLO      architectural HI / LO registers
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              iStart;
  logic [4:0]        iControlSignal;
  logic [DATA_W-1:0] iA;
  logic [DATA_W-1:0] iB;
  logic              oBusy;
  logic              oDone;
  logic              oDivByZero;
  logic [DATA_W-1:0] oHI;
  logic [DATA_W-1:0] oLO;

  modport master (
    output iStart, iControlSignal, iA, iB,
    input  oBusy, oDone, oDivByZero, oHI, oLO
  );

  modport slave (
    input  iStart, iControlSignal, iA, iB,
    output oBusy, oDone, oDivByZero, oHI, oLO
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative HI/LO multiply/divide unit. It handles MULT and MULTU with
//   radix-2 shift-add, and DIV and DIVU with restoring division. Each form
//   retires one bit per cycle and takes DATA_W cycles. MTHI and MTLO write
//   HI or LO in a single cycle.
//   Signed operations run on operand magnitudes. The sign fix-up is applied
//   on the edge that writes the result.
// Ports
//   iCLK  clock; every state update happens on the rising edge
//   iRST  asynchronous active-low reset
//   bus   mult_div_unit_if.slave (request, operands, status, HI/LO)
module mult_div_unit #(
  parameter int         DATA_W  = 32,
  parameter logic [4:0] OPMULT  = 5'd10,
  parameter logic [4:0] OPMULTU = 5'd11,
  parameter logic [4:0] OPDIV   = 5'd12,
  parameter logic [4:0] OPDIVU  = 5'd13,
  parameter logic [4:0] OPMTHI  = 5'd14,
  parameter logic [4:0] OPMTLO  = 5'd15
) (
  input  logic           iCLK,
  input  logic           iRST,
  mult_div_unit_if.slave bus
);

  localparam int               CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Control state (reset)
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              done;
  logic              dbz_pulse;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Iteration datapath (not reset; always reloaded on acceptance)
  // opnd   : multiplicand magnitude (MUL) or divisor magnitude (DIV)
  // acc_hi : partial-product high half (MUL) or partial remainder (DIV)
  // acc_lo : multiplier shifting out (MUL) or dividend-to-quotient (DIV)
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic              neg_q;
  logic              neg_r;
  logic              dbz;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  assign a_s = $signed(bus.iA);
  assign b_s = $signed(bus.iB);

  // Magnitude of an operand. Unsigned operations pass the operand through.
  // The most negative value maps to 2^(DATA_W-1), which is still correct as
  // an unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic sgn);
    logic [DATA_W-1:0] r;
    if (sgn && (v < 0)) r = $unsigned(-v);
    else                r = $unsigned(v);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    logic [DATA_W-1:0] r;
    if (neg) r = $unsigned(-$signed(v));
    else     r = v;
    return r;
  endfunction

  function automatic logic [2*DATA_W-1:0] fix_prod(input logic [2*DATA_W-1:0] p,
                                                   input logic neg);
    logic [2*DATA_W-1:0] r;
    if (neg) r = $unsigned(-$signed(p));
    else     r = p;
    return r;
  endfunction

  // Request decode
  logic is_mul, is_div, is_sgn, is_mthi, is_mtlo, can_accept, start_iter;
  assign is_mul     = (bus.iControlSignal == OPMULT) || (bus.iControlSignal == OPMULTU);
  assign is_div     = (bus.iControlSignal == OPDIV)  || (bus.iControlSignal == OPDIVU);
  assign is_sgn     = (bus.iControlSignal == OPMULT) || (bus.iControlSignal == OPDIV);
  assign is_mthi    = (bus.iControlSignal == OPMTHI);
  assign is_mtlo    = (bus.iControlSignal == OPMTLO);
  assign can_accept = bus.iStart && ((state == IDLE) || (state == DONE));
  assign start_iter = can_accept && (is_mul || is_div);

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the {acc_hi, acc_lo} pair right by one bit.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_nxt;
  logic [DATA_W-1:0] mul_lo_nxt;
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nxt = mul_sum[DATA_W:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};

  // Restoring step: shift in the next dividend bit and try to subtract.
  // When the trial fits, the true difference is below 2^DATA_W, so the
  // low DATA_W bits of the modular subtraction are exact.
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_fits;
  logic [DATA_W-1:0] div_hi_nxt;
  logic [DATA_W-1:0] div_lo_nxt;
  assign div_shift  = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff   = div_shift[DATA_W-1:0] - opnd;
  assign div_fits   = (div_shift >= {1'b0, opnd});
  assign div_hi_nxt = div_fits ? div_diff : div_shift[DATA_W-1:0];
  assign div_lo_nxt = {acc_lo[DATA_W-2:0], div_fits};

  // Final results, formed from the last iteration's next-state values.
  // A divide by zero leaves |dividend| in the remainder, and the sign
  // fix-up turns that back into iA. Only the quotient is forced.
  logic [2*DATA_W-1:0] prod_res;
  logic [DATA_W-1:0]   quo_res;
  logic [DATA_W-1:0]   rem_res;
  logic                last_iter;
  assign prod_res  = fix_prod({mul_hi_nxt, mul_lo_nxt}, neg_q);
  assign quo_res   = dbz ? '1 : fix_sign(div_lo_nxt, neg_q);
  assign rem_res   = fix_sign(div_hi_nxt, neg_r);
  assign last_iter = (cnt == CNT_W'(1));

  // Control FSM with registered status outputs
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz_pulse <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done      <= 1'b0;
      dbz_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.iStart) begin
            if (is_mthi) begin
              hi <= bus.iA;
            end else if (is_mtlo) begin
              lo <= bus.iA;
            end else if (is_mul) begin
              state <= MUL;
              cnt   <= ITERS;
              busy  <= 1'b1;
            end else if (is_div) begin
              state <= DIV;
              cnt   <= ITERS;
              busy  <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (state == MUL) begin
              {hi, lo} <= prod_res;
            end else begin
              hi        <= rem_res;
              lo        <= quo_res;
              dbz_pulse <= dbz;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration datapath: load on acceptance, then step once per cycle
  always_ff @(posedge iCLK) begin
    if (start_iter) begin
      opnd   <= is_mul ? abs_val(a_s, is_sgn) : abs_val(b_s, is_sgn);
      acc_hi <= '0;
      acc_lo <= is_mul ? abs_val(b_s, is_sgn) : abs_val(a_s, is_sgn);
      neg_q  <= is_sgn && (a_s[DATA_W-1] ^ b_s[DATA_W-1]);
      neg_r  <= is_sgn && a_s[DATA_W-1];
      dbz    <= is_div && (bus.iB == '0);
    end else if (state == MUL) begin
      acc_hi <= mul_hi_nxt;
      acc_lo <= mul_lo_nxt;
    end else if (state == DIV) begin
      acc_hi <= div_hi_nxt;
      acc_lo <= div_lo_nxt;
    end
  end

  assign bus.oBusy      = busy;
  assign bus.oDone      = done;
  assign bus.oDivByZero = dbz_pulse;
  assign bus.oHI        = hi;
  assign bus.oLO        = lo;

endmodule
